// File: rtl/axis_avg_buffer_pkg.sv
// Shared constants for the coherent averager: FSM state encodings and skid depth.
package axis_avg_buffer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_ACCUM = 2'd2;
  localparam logic [1:0] ST_READ  = 2'd3;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/axis_avg_buffer_if.sv
// AXI4-Stream bundle; master drives data/valid/last, slave returns ready.
interface axis_avg_buffer_if #(
  parameter int DW = 16
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_avg_buffer_ram.sv
// Simple dual-port accumulation RAM: one write port, registered read port (1-cycle latency).
module axis_avg_ram #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_dat_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_dat_q <= mem[raddr];
  end

  assign rdata = rd_dat_q;

endmodule

// File: rtl/axis_avg_buffer.sv
// Trigger-aligned coherent averager: sums avg_num+1 records point by point, then streams the sums.
// Input never stalls; output honours m_axis tready via a 2-entry skid, first word 2 cycles into READ.
module axis_avg_buffer
  import axis_avg_buffer_pkg::*;
#(
  parameter int    AXIS_TDATA_WIDTH  = 16,
  parameter int    SUM_WIDTH         = 32,
  parameter int    ADDR_WIDTH        = 10,
  parameter int    CNTR_WIDTH        = 16,
  parameter string AXIS_TDATA_SIGNED = "FALSE"
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_WIDTH-1:0] rec_len,
  input  logic [CNTR_WIDTH-1:0] avg_num,
  input  logic                  start,
  input  logic                  trigger,
  axis_avg_buffer_if.slave      s_axis,
  axis_avg_buffer_if.master     m_axis,
  output logic                  busy,
  output logic                  done,
  output logic [CNTR_WIDTH-1:0] rec_cntr
);

  localparam bit IS_SIGNED = (AXIS_TDATA_SIGNED == "TRUE");

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] rec_len_q, rec_len_d, sample_idx_q, sample_idx_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, acc_addr_q, acc_addr_d;
  logic [CNTR_WIDTH-1:0] avg_num_q, avg_num_d, rec_cntr_q, rec_cntr_d;
  logic                  acc_vld_q, acc_vld_d, acc_zero_q, acc_zero_d;
  logic [SUM_WIDTH-1:0]  acc_smp_q, acc_smp_d;
  logic                  rd_pend_q, rd_pend_d, rd_pend_last_q, rd_pend_last_d;
  logic                  rd_all_q, rd_all_d, done_q, done_d;
  logic [1:0]            skid_cnt_q, skid_cnt_d;
  logic [SUM_WIDTH-1:0]  skid0_dat_q, skid0_dat_d, skid1_dat_q, skid1_dat_d;
  logic                  skid0_last_q, skid0_last_d, skid1_last_q, skid1_last_d;

  logic signed [AXIS_TDATA_WIDTH-1:0] sample_s;
  logic [SUM_WIDTH-1:0]  sample_ext, ram_rdata, ram_wdata;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic                  accept, pop, push, rd_issue;
  logic [2:0]            inflight;

  assign sample_s = s_axis.tdata;
  always_comb begin
    if (IS_SIGNED) sample_ext = SUM_WIDTH'(sample_s);
    else           sample_ext = SUM_WIDTH'(s_axis.tdata);
  end

  assign accept = s_axis.tvalid &&
                  ((state_q == ST_ARM && trigger) || state_q == ST_ACCUM);

  assign m_axis.tvalid = (skid_cnt_q != 2'd0);
  assign m_axis.tlast  = m_axis.tvalid && skid0_last_q;
  assign m_axis.tdata  = skid0_dat_q;
  assign s_axis.tready = 1'b1;

  assign pop  = m_axis.tvalid && m_axis.tready;
  assign push = rd_pend_q;
  // Reads in flight plus words held must never exceed the skid, counting this cycle's pop.
  assign inflight = 3'(skid_cnt_q) + 3'(rd_pend_q) - 3'(pop);
  assign rd_issue = (state_q == ST_READ) && !rd_all_q && (inflight < 3'(SKID_DEPTH));

  always_comb begin
    ram_raddr = sample_idx_q;
    if (state_q == ST_READ)     ram_raddr = rd_addr_q;
    else if (state_q == ST_ARM) ram_raddr = '0;
  end

  // Record 0 ignores the RAM read so no clear pass is needed between runs.
  assign ram_wdata = (acc_zero_q ? '0 : ram_rdata) + acc_smp_q;

  axis_avg_ram #(.AW(ADDR_WIDTH), .DW(SUM_WIDTH)) u_ram (
    .clk   (aclk),
    .we    (acc_vld_q),
    .waddr (acc_addr_q),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d        = state_q;
    rec_len_d      = rec_len_q;
    avg_num_d      = avg_num_q;
    sample_idx_d   = sample_idx_q;
    rec_cntr_d     = rec_cntr_q;
    rd_addr_d      = rd_addr_q;
    rd_all_d       = rd_all_q;
    done_d         = 1'b0;
    acc_vld_d      = accept;
    acc_addr_d     = (state_q == ST_ARM) ? '0 : sample_idx_q;
    acc_smp_d      = sample_ext;
    acc_zero_d     = (rec_cntr_q == '0);
    rd_pend_d      = rd_issue;
    rd_pend_last_d = (rd_addr_q == rec_len_q);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rec_len_d    = rec_len;
          avg_num_d    = avg_num;
          rec_cntr_d   = '0;
          sample_idx_d = '0;
          rd_addr_d    = '0;
          rd_all_d     = 1'b0;
          state_d      = ST_ARM;
        end
      end
      ST_ARM: begin
        if (accept) begin
          sample_idx_d = ADDR_WIDTH'(1);
          state_d      = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (s_axis.tvalid) begin
          if (sample_idx_q == rec_len_q) begin
            sample_idx_d = '0;
            rec_cntr_d   = rec_cntr_q + CNTR_WIDTH'(1);
            state_d      = (rec_cntr_q == avg_num_q) ? ST_READ : ST_ARM;
          end else begin
            sample_idx_d = sample_idx_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_READ: begin
        if (rd_issue) begin
          if (rd_addr_q == rec_len_q) rd_all_d = 1'b1;
          else                        rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
        end
        if (pop && m_axis.tlast) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    skid_cnt_d   = skid_cnt_q;
    skid0_dat_d  = skid0_dat_q;
    skid0_last_d = skid0_last_q;
    skid1_dat_d  = skid1_dat_q;
    skid1_last_d = skid1_last_q;
    case ({push, pop})
      2'b10: begin
        if (skid_cnt_q == 2'd0) begin
          skid0_dat_d  = ram_rdata;
          skid0_last_d = rd_pend_last_q;
        end else begin
          skid1_dat_d  = ram_rdata;
          skid1_last_d = rd_pend_last_q;
        end
        skid_cnt_d = skid_cnt_q + 2'd1;
      end
      2'b01: begin
        skid0_dat_d  = skid1_dat_q;
        skid0_last_d = skid1_last_q;
        skid_cnt_d   = skid_cnt_q - 2'd1;
      end
      2'b11: begin
        if (skid_cnt_q == 2'd1) begin
          skid0_dat_d  = ram_rdata;
          skid0_last_d = rd_pend_last_q;
        end else begin
          skid0_dat_d  = skid1_dat_q;
          skid0_last_d = skid1_last_q;
          skid1_dat_d  = ram_rdata;
          skid1_last_d = rd_pend_last_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= ST_IDLE;
      rec_len_q      <= '0;
      avg_num_q      <= '0;
      sample_idx_q   <= '0;
      rec_cntr_q     <= '0;
      rd_addr_q      <= '0;
      rd_all_q       <= 1'b0;
      done_q         <= 1'b0;
      acc_vld_q      <= 1'b0;
      acc_addr_q     <= '0;
      acc_smp_q      <= '0;
      acc_zero_q     <= 1'b0;
      rd_pend_q      <= 1'b0;
      rd_pend_last_q <= 1'b0;
      skid_cnt_q     <= '0;
      skid0_dat_q    <= '0;
      skid0_last_q   <= 1'b0;
      skid1_dat_q    <= '0;
      skid1_last_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      rec_len_q      <= rec_len_d;
      avg_num_q      <= avg_num_d;
      sample_idx_q   <= sample_idx_d;
      rec_cntr_q     <= rec_cntr_d;
      rd_addr_q      <= rd_addr_d;
      rd_all_q       <= rd_all_d;
      done_q         <= done_d;
      acc_vld_q      <= acc_vld_d;
      acc_addr_q     <= acc_addr_d;
      acc_smp_q      <= acc_smp_d;
      acc_zero_q     <= acc_zero_d;
      rd_pend_q      <= rd_pend_d;
      rd_pend_last_q <= rd_pend_last_d;
      skid_cnt_q     <= skid_cnt_d;
      skid0_dat_q    <= skid0_dat_d;
      skid0_last_q   <= skid0_last_d;
      skid1_dat_q    <= skid1_dat_d;
      skid1_last_q   <= skid1_last_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign rec_cntr = rec_cntr_q;

endmodule

// File: tb/tb_axis_avg_buffer.sv
// Randomised bench for axis_avg_buffer: unsigned/32, signed/32 and unsigned/16 (wrapping) instances
// share one stimulus stream and are compared against a point-by-point sum model.
module tb_axis_avg_buffer;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [9:0]  rec_len = '0;
  logic [15:0] avg_num = '0;
  logic        start = 1'b0, trigger = 1'b0, s_tvalid = 1'b0, m_tready = 1'b0;
  logic [15:0] s_tdata = '0;

  logic        busy_u, busy_s, busy_w, done_u, done_s, done_w;
  logic [15:0] rec_cntr_u, rec_cntr_s, rec_cntr_w;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] samp [16][64];
  logic [31:0] exp_u [64];
  logic [31:0] exp_s [64];
  logic [15:0] exp_w [64];

  always #5 aclk = ~aclk;

  axis_avg_buffer_if #(.DW(16)) s_u (), s_s (), s_w ();
  axis_avg_buffer_if #(.DW(32)) m_u (), m_s ();
  axis_avg_buffer_if #(.DW(16)) m_w ();

  assign s_u.tdata = s_tdata;  assign s_u.tvalid = s_tvalid;  assign s_u.tlast = 1'b0;
  assign s_s.tdata = s_tdata;  assign s_s.tvalid = s_tvalid;  assign s_s.tlast = 1'b0;
  assign s_w.tdata = s_tdata;  assign s_w.tvalid = s_tvalid;  assign s_w.tlast = 1'b0;
  assign m_u.tready = m_tready;
  assign m_s.tready = m_tready;
  assign m_w.tready = m_tready;

  axis_avg_buffer #(.AXIS_TDATA_WIDTH(16), .SUM_WIDTH(32), .AXIS_TDATA_SIGNED("FALSE")) u_uns (
    .aclk(aclk), .aresetn(aresetn), .rec_len(rec_len), .avg_num(avg_num), .start(start),
    .trigger(trigger), .s_axis(s_u), .m_axis(m_u), .busy(busy_u), .done(done_u), .rec_cntr(rec_cntr_u));

  axis_avg_buffer #(.AXIS_TDATA_WIDTH(16), .SUM_WIDTH(32), .AXIS_TDATA_SIGNED("TRUE")) u_sgn (
    .aclk(aclk), .aresetn(aresetn), .rec_len(rec_len), .avg_num(avg_num), .start(start),
    .trigger(trigger), .s_axis(s_s), .m_axis(m_s), .busy(busy_s), .done(done_s), .rec_cntr(rec_cntr_s));

  axis_avg_buffer #(.AXIS_TDATA_WIDTH(16), .SUM_WIDTH(16), .AXIS_TDATA_SIGNED("FALSE")) u_wrap (
    .aclk(aclk), .aresetn(aresetn), .rec_len(rec_len), .avg_num(avg_num), .start(start),
    .trigger(trigger), .s_axis(s_w), .m_axis(m_w), .busy(busy_w), .done(done_w), .rec_cntr(rec_cntr_w));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected output word i is the modular sum over records of sample i, extended per instance.
  task automatic gen(input int mode, input int len, input int num);
    for (int r = 0; r <= num; r++)
      for (int i = 0; i <= len; i++)
        case (mode)
          0:       samp[r][i] = 16'(i + 1);
          1:       samp[r][i] = 16'hFFFF;
          default: samp[r][i] = 16'($urandom);
        endcase
    for (int i = 0; i <= len; i++) begin
      longint su, ss;
      su = 0;
      ss = 0;
      for (int r = 0; r <= num; r++) begin
        su += longint'(samp[r][i]);
        ss += longint'($signed(samp[r][i]));
      end
      exp_u[i] = su[31:0];
      exp_s[i] = ss[31:0];
      exp_w[i] = su[15:0];
    end
  endtask

  task automatic beat(input logic v, input logic t, input logic [15:0] d);
    s_tvalid = v;
    trigger  = t;
    s_tdata  = d;
    @(negedge aclk);
  endtask

  task automatic do_start(input int len, input int num);
    rec_len = 10'(len);
    avg_num = 16'(num);
    start   = 1'b1;
    beat(1'b0, 1'b0, 16'h0);
    start   = 1'b0;
    rec_len = 10'($urandom);
    avg_num = 16'($urandom);
  endtask

  task automatic send_record(input int r, input int nsamp, input bit noise, input bit start_mid);
    if (noise)
      repeat ($urandom_range(0, 3)) begin
        if ($urandom % 2 == 0) beat(1'b1, 1'b0, 16'($urandom));
        else                   beat(1'b0, 1'b1, 16'($urandom));
      end
    beat(1'b1, 1'b1, samp[r][0]);
    check("busy_in_run", 64'(busy_u), 64'(1));
    for (int i = 1; i < nsamp; i++) begin
      if (noise && $urandom % 3 == 0) beat(1'b0, 1'($urandom), 16'($urandom));
      if (start_mid && i == 1) start = 1'b1;
      beat(1'b1, noise ? 1'($urandom) : 1'b0, samp[r][i]);
      start = 1'b0;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_tvalid"}, 64'(m_u.tvalid), 64'(0));
    check({tag, "_tlast"},  64'(m_u.tlast),  64'(0));
    check({tag, "_tdata"},  64'(m_u.tdata),  64'(0));
    check({tag, "_busy"},   64'(busy_u),     64'(0));
    check({tag, "_done"},   64'(done_u),     64'(0));
    check({tag, "_cntr"},   64'(rec_cntr_u), 64'(0));
    check({tag, "_w_tdata"}, 64'(m_w.tdata), 64'(0));
    check({tag, "_s_busy"}, 64'(busy_s),     64'(0));
  endtask

  task automatic drain(input int len, input int num, input bit bp);
    int          k = 0;
    bit          fin = 0, last_hs = 0, prev_stall = 0, pl = 0;
    logic [31:0] pd = '0;
    for (int c = 0; c < 2000 && !fin; c++) begin
      if (c == 0) begin
        check("rec_cntr_end", 64'(rec_cntr_u), 64'(num + 1));
        check("rec_cntr_end_w", 64'(rec_cntr_w), 64'(num + 1));
      end
      if (c < 2)  check("lat_idle", 64'(m_u.tvalid), 64'(0));
      if (c == 2) check("lat_first", 64'(m_u.tvalid), 64'(1));
      if (prev_stall) begin
        check("stall_vld",  64'(m_u.tvalid), 64'(1));
        check("stall_dat",  64'(m_u.tdata),  64'(pd));
        check("stall_last", 64'(m_u.tlast),  64'(pl));
      end
      if (last_hs) begin
        check("done_pulse", 64'(done_u), 64'(1));
        check("done_busy",  64'(busy_u), 64'(0));
        check("done_pulse_s", 64'(done_s), 64'(1));
        check("done_pulse_w", 64'(done_w), 64'(1));
        fin = 1;
      end
      s_tvalid = 1'($urandom);
      trigger  = 1'($urandom);
      s_tdata  = 16'($urandom);
      m_tready = bp ? 1'($urandom) : 1'b1;
      if (m_u.tvalid && m_tready && !fin) begin
        check("word_u", 64'(m_u.tdata), 64'(exp_u[k]));
        check("word_s", 64'(m_s.tdata), 64'(exp_s[k]));
        check("word_w", 64'(m_w.tdata), 64'(exp_w[k]));
        check("tlast",  64'(m_u.tlast), 64'(k == len));
        if (k == len) last_hs = 1;
        k++;
      end
      prev_stall = m_u.tvalid && !m_tready;
      pd = m_u.tdata;
      pl = m_u.tlast;
      @(negedge aclk);
    end
    check("drain_finished", 64'(fin), 64'(1));
    check("word_count", 64'(k), 64'(len + 1));
    check("done_low", 64'(done_u), 64'(0));
    check("no_extra_vld", 64'(m_u.tvalid), 64'(0));
    check("rec_cntr_hold", 64'(rec_cntr_u), 64'(num + 1));
    s_tvalid = 1'b0;
    trigger  = 1'b0;
    m_tready = 1'b0;
  endtask

  task automatic run(input int len, input int num, input int mode, input bit noise, input bit bp);
    gen(mode, len, num);
    do_start(len, num);
    for (int r = 0; r <= num; r++) send_record(r, len + 1, noise, noise && r == 0);
    drain(len, num, bp);
  endtask

  initial begin
    repeat (3) @(negedge aclk);
    check_reset("reset");
    aresetn = 1'b1;
    @(negedge aclk);

    run(3, 2, 0, 1'b0, 1'b0);    // 3,6,9,12
    run(5, 3, 1, 1'b0, 1'b0);    // signed -4 per point
    run(4, 1, 1, 1'b1, 1'b1);    // 16-bit wrap to FFFE
    for (int t = 0; t < 6; t++)
      run($urandom_range(1, 20), $urandom_range(0, 5), 2, 1'b1, 1'b1);

    gen(2, 7, 4);
    do_start(7, 4);
    send_record(0, 8, 1'b0, 1'b0);
    send_record(1, 8, 1'b0, 1'b0);
    send_record(2, 3, 1'b0, 1'b0);
    aresetn = 1'b0;
    @(negedge aclk);
    check_reset("abort");
    aresetn = 1'b1;
    @(negedge aclk);
    run(7, 0, 2, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
